pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Upstream control stage for the 5-stage pipeline; generates its en/stall inputs.
//  Turns hazard requests into registered control: load-use (1-cycle stall), mul/div (MD_LAT-cycle stall),
//  branch flush and halt-with-drain.
//  Watches the pipeline's packed per-stage state bus to detect when the pipeline is empty.
// PARAMETERS
//  STAGES     5    pipeline stage count
//  SW         3    state bits per stage; state_flat width = STAGES*SW (15)
//  MD_LAT     4    stall cycles per md_start (>=1)
//  DRAIN_MAX  16   max DRAIN cycles before forced halt
//  CNT_W      16   stall_cycles counter width
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous, active-high reset
//  start         in   1         leave IDLE/HALTED and run
//  load_use      in   1         load-use hazard, 1-cycle pulse
//  md_start      in   1         mul/div issue, 1-cycle pulse
//  branch_taken  in   1         taken branch, 1-cycle pulse
//  halt_req      in   1         request orderly stop
//  state_flat    in   STAGES*SW pipeline stage states; field k = [k*SW +: SW]; 0 = bubble
//  en            out  1         pipeline enable
//  stall         out  1         pipeline stall
//  flush         out  1         squash IF/ID, 1-cycle pulse
//  drain         out  1         fetch gate; high in DRAIN
//  halted        out  1         high in HALTED
//  timeout       out  1         sticky: DRAIN hit DRAIN_MAX; cleared by rst or start
//  stall_cycles  out  CNT_W     cycles with stall=1, saturating
// BEHAVIOUR
//  - All outputs are registered. Reset: FSM=IDLE; every output 0, counters 0.
//  - Each output reflects the FSM state one cycle after the triggering input edge.
//  - FSM states:
//    - IDLE: en=0. start -> RUN.
//    - RUN: en=1, stall=0. Priority: branch_taken > md_start > load_use > halt_req.
//      - branch_taken -> FLUSH.
//      - md_start -> STALL, cnt=MD_LAT-1.
//      - load_use -> STALL, cnt=0.
//      - halt_req -> DRAIN, dcnt=0.
//    - STALL: en=1, stall=1.
//      - cnt==0 -> RUN, or FLUSH if a branch is pending.
//      - Otherwise cnt--.
//      - md_start here reloads cnt=MD_LAT-1. load_use here is ignored.
//      - branch_taken here sets br_pend; the flush fires when the stall ends.
//      - halt_req here sets halt_pend; DRAIN is entered once back in RUN.
//    - FLUSH: en=1, stall=0, flush=1 for exactly 1 cycle -> RUN. Requests in FLUSH are ignored except halt_req (pended).
//    - DRAIN: en=1, drain=1. New hazard requests are ignored.
//      - All SW-bit fields of state_flat == 0 -> HALTED.
//      - Else dcnt==DRAIN_MAX-1 -> HALTED with timeout=1.
//      - Else dcnt++.
//    - HALTED: en=0, halted=1. start -> RUN (clears timeout and pends).
//  - start outside IDLE/HALTED: ignored.
//  - Simultaneous md_start+load_use in RUN: a single MD_LAT stall, not additive.
//  - rst asserted mid-STALL/DRAIN: next edge returns to IDLE, outputs 0, pends cleared.
//  - stall_cycles: +1 each cycle stall=1. Holds at 2^CNT_W-1. Not cleared by start.
// CONFIGURATION
//  HAZ_PERF_CNT_EN:
//    - Defined: stall_cycles counter implemented as above.
//    - Undefined: no counter flops; stall_cycles tied to 0.
//  FSM and all other outputs are identical in both builds.
// TESTING
//  1. rst=1 2 cycles, release, start pulse: en=0 until the cycle after start, then en=1; stall=flush=0.
//  2. RUN, load_use 1 cycle: stall=1 for exactly 1 cycle, then RUN; stall_cycles=1 (macro on) / 0 (off).
//  3. RUN, md_start; branch_taken 2 cycles later: stall=1 4 cycles, then flush=1 1 cycle, then RUN.
//  4. halt_req, state_flat=15'h0049 for 3 cycles then 0: drain=1 4 cycles, then halted=1, en=0, timeout=0.
//  5. halt_req, state_flat held 15'h0001: HALTED after 16 DRAIN cycles, timeout=1; start -> RUN, timeout=0.
//  6. rst during STALL (cnt=2): next cycle en=stall=0, FSM IDLE; later start -> RUN with no stray stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: registered stall/flush/drain control for the 5-stage pipeline
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int SW        = 3,
  parameter int MD_LAT    = 4,
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_use,
  input  logic                 md_start,
  input  logic                 branch_taken,
  input  logic                 halt_req,
  input  logic [STAGES*SW-1:0] state_flat,
  output logic                 en,
  output logic                 stall,
  output logic                 flush,
  output logic                 drain,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_W-1:0]     stall_cycles
);
  localparam int CW = MD_LAT > 1 ? $clog2(MD_LAT) : 1;
  localparam int DW = DRAIN_MAX > 1 ? $clog2(DRAIN_MAX) : 1;
  typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, DRAIN, HALTED} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic br_pend, br_pend_n, halt_pend, halt_pend_n, timeout_n;
  logic empty;
  assign empty = ~|state_flat;
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dcnt_n      = dcnt;
    br_pend_n   = br_pend;
    halt_pend_n = halt_pend;
    timeout_n   = timeout;
    case (state)
      IDLE: if (start) begin
        state_n   = RUN;
        timeout_n = 1'b0;
      end
      RUN: begin
        if (branch_taken) state_n = FLUSH;
        else if (md_start) begin
          state_n = STALL;
          cnt_n   = CW'(MD_LAT - 1);
        end else if (load_use) begin
          state_n = STALL;
          cnt_n   = '0;
        end else if (halt_req || halt_pend) begin
          state_n     = DRAIN;
          dcnt_n      = '0;
          halt_pend_n = 1'b0;
        end
      end
      STALL: begin
        br_pend_n   = br_pend | branch_taken;
        halt_pend_n = halt_pend | halt_req;
        // a new mul/div extends the current stall rather than queueing behind it
        if (md_start) cnt_n = CW'(MD_LAT - 1);
        else if (cnt == '0) begin
          state_n   = (br_pend || branch_taken) ? FLUSH : RUN;
          br_pend_n = 1'b0;
        end else cnt_n = cnt - CW'(1);
      end
      FLUSH: begin
        halt_pend_n = halt_pend | halt_req;
        state_n     = RUN;
      end
      DRAIN: begin
        if (empty) state_n = HALTED;
        else if (dcnt == DW'(DRAIN_MAX - 1)) begin
          state_n   = HALTED;
          timeout_n = 1'b1;
        end else dcnt_n = dcnt + DW'(1);
      end
      HALTED: if (start) begin
        state_n     = RUN;
        timeout_n   = 1'b0;
        br_pend_n   = 1'b0;
        halt_pend_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      br_pend   <= 1'b0;
      halt_pend <= 1'b0;
      timeout   <= 1'b0;
      en        <= 1'b0;
      stall     <= 1'b0;
      flush     <= 1'b0;
      drain     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dcnt      <= dcnt_n;
      br_pend   <= br_pend_n;
      halt_pend <= halt_pend_n;
      timeout   <= timeout_n;
      en        <= state_n inside {RUN, STALL, FLUSH, DRAIN};
      stall     <= state_n == STALL;
      flush     <= state_n == FLUSH;
      drain     <= state_n == DRAIN;
      halted    <= state_n == HALTED;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] sc;
  always_ff @(posedge clk) begin
    if (rst) sc <= '0;
    else if (stall && ~&sc) sc <= sc + CNT_W'(1);
  end
  assign stall_cycles = sc;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random hazard traffic against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4, DRAIN_MAX = 16, CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_FLUSH = 3, M_DRAIN = 4, M_HALTED = 5;
  logic clk = 1'b0;
  logic rst, start, load_use, md_start, branch_taken, halt_req;
  logic [14:0] state_flat;
  logic en, stall, flush, drain, halted, timeout;
  logic [CNT_W-1:0] stall_cycles;
  int n_chk = 0, n_fail = 0;
  int m_mode, m_left, m_dc, m_sc;
  bit m_br, m_hp, m_to;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .load_use(load_use), .md_start(md_start),
    .branch_taken(branch_taken), .halt_req(halt_req), .state_flat(state_flat),
    .en(en), .stall(stall), .flush(flush), .drain(drain), .halted(halted),
    .timeout(timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m_left = stall cycles still to be spent, m_dc = drain cycles already spent
  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; m_dc = 0; m_sc = 0;
      m_br = 0; m_hp = 0; m_to = 0;
      return;
    end
    if (m_mode == M_STALL && m_sc < (1 << CNT_W) - 1) m_sc++;
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_RUN; m_to = 0; end
      M_RUN:
        if (branch_taken) m_mode = M_FLUSH;
        else if (md_start) begin m_mode = M_STALL; m_left = MD_LAT; end
        else if (load_use) begin m_mode = M_STALL; m_left = 1; end
        else if (halt_req || m_hp) begin m_mode = M_DRAIN; m_dc = 0; m_hp = 0; end
      M_STALL: begin
        m_hp = m_hp | halt_req;
        if (md_start) begin m_left = MD_LAT; m_br = m_br | branch_taken; end
        else if (m_left == 1) begin
          m_mode = (m_br || branch_taken) ? M_FLUSH : M_RUN;
          m_br = 0;
        end else begin m_left--; m_br = m_br | branch_taken; end
      end
      M_FLUSH: begin m_hp = m_hp | halt_req; m_mode = M_RUN; end
      M_DRAIN:
        if (state_flat == 0) m_mode = M_HALTED;
        else if (m_dc + 1 == DRAIN_MAX) begin m_mode = M_HALTED; m_to = 1; end
        else m_dc++;
      M_HALTED: if (start) begin m_mode = M_RUN; m_to = 0; m_br = 0; m_hp = 0; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    check("en", en, m_mode inside {M_RUN, M_STALL, M_FLUSH, M_DRAIN});
    check("stall", stall, m_mode == M_STALL);
    check("flush", flush, m_mode == M_FLUSH);
    check("drain", drain, m_mode == M_DRAIN);
    check("halted", halted, m_mode == M_HALTED);
    check("timeout", timeout, m_to);
    check("stall_cycles", stall_cycles, PERF ? m_sc : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    start = 0; load_use = 0; md_start = 0; branch_taken = 0; halt_req = 0;
  endtask

  initial begin
    int ns, nf, nd;
    bit zp;
    rst = 1; idle_inputs(); state_flat = '0;
    m_mode = M_IDLE; m_left = 0; m_dc = 0; m_sc = 0; m_br = 0; m_hp = 0; m_to = 0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;
    cycle();
    check("t1_en_before_start", en, 0);
    start = 1; cycle(); start = 0;
    check("t1_en_after_start", en, 1);
    cycle();
    load_use = 1; cycle(); load_use = 0;
    check("t2_stall", stall, 1);
    cycle();
    check("t2_stall_end", stall, 0);
    check("t2_stall_cycles", stall_cycles, PERF ? 1 : 0);
    ns = 0; nf = 0;
    for (int i = 0; i < 10; i++) begin
      md_start = (i == 0); branch_taken = (i == 2);
      cycle();
      ns += int'(stall); nf += int'(flush);
    end
    check("t3_stall_len", ns, 4);
    check("t3_flush_len", nf, 1);
    check("t3_run", en & ~stall, 1);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      halt_req = (i == 0); state_flat = (i < 4) ? 15'h0049 : 15'h0;
      cycle();
      nd += int'(drain);
    end
    check("t4_drain_len", nd, 4);
    check("t4_halted", {halted, en, timeout}, 3'b100);
    start = 1; cycle(); start = 0;
    nd = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      halt_req = (i == 0); state_flat = 15'h0001;
      cycle();
      nd += int'(drain);
    end
    halt_req = 0;
    check("t5_drain_len", nd, DRAIN_MAX);
    check("t5_halted", halted, 1);
    check("t5_timeout", timeout, 1);
    state_flat = '0;
    start = 1; cycle(); start = 0;
    check("t5_restart", {en, timeout}, 2'b10);
    md_start = 1; cycle(); md_start = 0; cycle();
    check("t6_in_stall", stall, 1);
    rst = 1; cycle(); rst = 0;
    check("t6_reset", {en, stall}, 2'b00);
    cycle();
    start = 1; cycle(); start = 0;
    cycle();
    check("t6_no_stray_stall", {en, stall}, 2'b10);
    zp = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) zp = $urandom_range(0, 1) == 0;
      rst          = $urandom_range(0, 299) == 0;
      start        = $urandom_range(0, 15) == 0;
      load_use     = $urandom_range(0, 5) == 0;
      md_start     = $urandom_range(0, 9) == 0;
      branch_taken = $urandom_range(0, 7) == 0;
      halt_req     = $urandom_range(0, 19) == 0;
      state_flat   = (zp && $urandom_range(0, 2) == 0) ? 15'h0 : 15'($urandom_range(1, 32767));
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
